time_display_scanner: RTL and testbench

- Reads the 12-bit BCD remaining-time word (minutes, seconds-tens, seconds-ones) produced by the charging-station countdown counter.
- Drives a 3-digit multiplexed common-cathode 7-segment display plus colon.
- Provides leading-zero blanking, tear-free frame capture, invalid-digit indication, and an expiry flag with blinking display.
- Sits between the counter and the board display pins.

---
 rtl/time_display_scanner_if.sv | 25 ++
 rtl/time_display_scanner.sv | 155 +++++++++++++++
 tb/tb_time_display_scanner.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/time_display_scanner_if.sv
// Time-word and display-pin bundle for time_display_scanner.
// The Brightness signal exists only when DISPLAY_DIM_EN is defined.
interface time_display_scanner_if;
  logic [11:0] PresentTime;
  logic        Active;
`ifdef DISPLAY_DIM_EN
  logic [1:0]  Brightness;
`endif
  logic [6:0]  Segments;
  logic [2:0]  DigitSel;
  logic        Colon;
  logic        Expired;

`ifdef DISPLAY_DIM_EN
  modport master (output PresentTime, Active, Brightness,
                  input  Segments, DigitSel, Colon, Expired);
  modport slave  (input  PresentTime, Active, Brightness,
                  output Segments, DigitSel, Colon, Expired);
`else
  modport master (output PresentTime, Active,
                  input  Segments, DigitSel, Colon, Expired);
  modport slave  (input  PresentTime, Active,
                  output Segments, DigitSel, Colon, Expired);
`endif
endinterface

// File: rtl/time_display_scanner.sv
// Multiplexed 3-digit 7-segment scanner with frame shadowing, blanking and expiry blink.
// Optional macro DISPLAY_DIM_EN adds Brightness-controlled per-slot duty dimming.
module time_display_scanner #(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic                  Clk,
  input  logic                  Reset,
  time_display_scanner_if.slave bus
);
  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_MIN  = 2'd2
  } slot_e;

  slot_e         state_q, state_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [11:0]   shadow_q, shadow_d;
  logic [BW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;
  logic          expired_q, expired_d;
  logic [6:0]    segments_q, segments_d;
  logic [2:0]    digit_sel_q, digit_sel_d;
  logic          colon_q, colon_d;
  logic          tick, frame_start, blank_off;
  logic [3:0]    digit;
`ifdef DISPLAY_DIM_EN
  logic [1:0]    bright_q, bright_d;
  logic [31:0]   dim_lim;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  assign tick        = (prescaler_q == PW'(REFRESH_DIV - 1));
  assign frame_start = tick && (state_q == SLOT_MIN);

  // State and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= SLOT_ONES;
      prescaler_q <= '0;
      shadow_q    <= '0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
      expired_q   <= 1'b0;
      segments_q  <= '0;
      digit_sel_q <= 3'b001;
      colon_q     <= 1'b0;
`ifdef DISPLAY_DIM_EN
      bright_q    <= 2'd3;
`endif
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      shadow_q    <= shadow_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      expired_q   <= expired_d;
      segments_q  <= segments_d;
      digit_sel_q <= digit_sel_d;
      colon_q     <= colon_d;
`ifdef DISPLAY_DIM_EN
      bright_q    <= bright_d;
`endif
    end
  end

  // Next state: scan slot, prescaler, and frame-start capture/expiry/blink
  always_comb begin
    state_d     = state_q;
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    shadow_d    = shadow_q;
    expired_d   = expired_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
`ifdef DISPLAY_DIM_EN
    bright_d    = bright_q;
`endif
    if (tick) begin
      case (state_q)
        SLOT_ONES: state_d = SLOT_TENS;
        SLOT_TENS: state_d = SLOT_MIN;
        default:   state_d = SLOT_ONES;
      endcase
    end
    if (frame_start) begin
      shadow_d = bus.PresentTime;
`ifdef DISPLAY_DIM_EN
      bright_d = bus.Brightness;
`endif
      if (bus.Active && (bus.PresentTime == 12'h000) && (shadow_q != 12'h000)) begin
        expired_d = 1'b1;
      end else if ((bus.PresentTime != 12'h000) || !bus.Active) begin
        expired_d = 1'b0;
      end
      if (expired_d && !expired_q) begin
        frame_cnt_d = '0;
        phase_d     = 1'b0;
      end else if (expired_q) begin
        if (frame_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          frame_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + BW'(1);
        end
      end
    end
  end

`ifdef DISPLAY_DIM_EN
  assign dim_lim = ((32'(bright_q) + 32'd1) * 32'(REFRESH_DIV)) / 32'd4;
`endif

  // Display outputs from the current slot and shadow
  always_comb begin
    digit       = shadow_q[3:0];
    digit_sel_d = 3'b001;
    case (state_q)
      SLOT_TENS: begin digit = shadow_q[7:4];  digit_sel_d = 3'b010; end
      SLOT_MIN:  begin digit = shadow_q[11:8]; digit_sel_d = 3'b100; end
      default:   begin digit = shadow_q[3:0];  digit_sel_d = 3'b001; end
    endcase
    blank_off  = expired_q && phase_q;
    segments_d = seg_decode(digit);
    if ((state_q == SLOT_MIN) && (digit == 4'd0)) segments_d = '0;
    if (blank_off) segments_d = '0;
`ifdef DISPLAY_DIM_EN
    if (32'(prescaler_q) >= dim_lim) segments_d = '0;
`endif
    colon_d = bus.Active && !blank_off;
  end

  assign bus.Segments = segments_q;
  assign bus.DigitSel = digit_sel_q;
  assign bus.Colon    = colon_q;
  assign bus.Expired  = expired_q;
endmodule

// File: tb/tb_time_display_scanner.sv
// Scoreboard bench for time_display_scanner: a cycle-level reference model queues
// expected outputs, a monitor on the falling edge compares them against the DUT.
module tb_time_display_scanner;
`ifdef DISPLAY_DIM_EN
  localparam int unsigned DIV = 8;
`else
  localparam int unsigned DIV = 4;
`endif
  localparam int unsigned BLINK = 2;
  localparam int unsigned FRAME = 3 * DIV;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                          7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40,
                                          7'h40, 7'h40};

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] dsel;
    logic       colon;
    logic       exp;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int unsigned k = 0;

  time_display_scanner_if tif();

  time_display_scanner #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BLINK)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (tif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_seg",   32'(tif.Segments), 32'h00);
    check("rst_dsel",  32'(tif.DigitSel), 32'h1);
    check("rst_colon", 32'(tif.Colon),    32'h0);
    check("rst_exp",   32'(tif.Expired),  32'h0);
  endtask

  // Reference model: k counts clock edges since reset release; a frame is
  // FRAME edges long and each new frame's time word is latched on its last edge.
  initial begin : model
    logic [11:0] m_shadow;
    logic        m_exp;
    int unsigned m_frames;
    logic [1:0]  m_bright;
    int unsigned slot, pres;
    logic [3:0]  dg;
    logic        dark;
    logic [11:0] nt;
    obs_t        o;
    m_shadow = '0; m_exp = 1'b0; m_frames = 0; m_bright = 2'd3;
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0; m_shadow = '0; m_exp = 1'b0; m_frames = 0; m_bright = 2'd3;
      end else begin
        slot   = (k / DIV) % 3;
        pres   = k % DIV;
        dg     = 4'(m_shadow >> (4 * slot));
        dark   = m_exp && (((m_frames / BLINK) % 2) == 1);
        o.seg  = SEG_TAB[dg];
        if (slot == 2 && dg == 4'd0) o.seg = '0;
        if (dark) o.seg = '0;
`ifdef DISPLAY_DIM_EN
        if (pres >= ((32'(m_bright) + 1) * DIV) / 4) o.seg = '0;
`endif
        o.dsel  = 3'(1 << slot);
        o.colon = tif.Active && !dark;
        if ((k + 1) % FRAME == 0) begin
          nt = tif.PresentTime;
`ifdef DISPLAY_DIM_EN
          m_bright = tif.Brightness;
`endif
          if (tif.Active && nt == 12'h000 && m_shadow != 12'h000) begin
            if (!m_exp) m_frames = 0;
            else m_frames++;
            m_exp = 1'b1;
          end else begin
            if (m_exp) m_frames++;
            if (nt != 12'h000 || !tif.Active) m_exp = 1'b0;
          end
          m_shadow = nt;
        end
        o.exp = m_exp;
        exp_q.push_back(o);
        k++;
      end
    end
  end

  // Monitor: one expected observation per clock, compared mid-cycle
  initial begin : monitor
    obs_t o;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        o = exp_q.pop_front();
        check("segments", 32'(tif.Segments), 32'(o.seg));
        check("digitsel", 32'(tif.DigitSel), 32'(o.dsel));
        check("colon",    32'(tif.Colon),    32'(o.colon));
        check("expired",  32'(tif.Expired),  32'(o.exp));
      end
    end
  end

  function automatic logic [11:0] rnd_time();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 12'h000;
    if (r == 1) return 12'h001;
    return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
  endfunction

  initial begin : stim
    int guard;
    tif.PresentTime = 12'h000;
    tif.Active      = 1'b0;
`ifdef DISPLAY_DIM_EN
    tif.Brightness  = 2'd1;
`endif
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    tif.Active = 1'b1;
    tif.PresentTime = 12'h159;
    run(3 * FRAME);
    run(DIV + 1);
    tif.PresentTime = 12'h158;
    run(2 * FRAME);
    tif.PresentTime = 12'h059;
    run(2 * FRAME);
    tif.PresentTime = 12'h1A9;
    run(2 * FRAME);
    tif.PresentTime = 12'h001;
    run(2 * FRAME);
    tif.PresentTime = 12'h000;
    run(9 * FRAME);
    tif.PresentTime = 12'h100;
    run(2 * FRAME);
    tif.PresentTime = 12'h001;
    run(2 * FRAME);
    tif.PresentTime = 12'h000;
    run(3 * FRAME);
    tif.Active = 1'b0;
    run(2 * FRAME);
    // Land in the tens slot with the display lit, then reset asynchronously
    tif.Active = 1'b1;
    tif.PresentTime = 12'h159;
    run(2 * FRAME);
    guard = 0;
    while (!((k % FRAME) > DIV && (k % FRAME) < 2 * DIV) && guard < 4 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    check("reset_align_timeout", 32'(guard < 4 * FRAME), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    run(3);
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) tif.PresentTime = rnd_time();
      if ($urandom_range(0, 59) == 0) tif.Active = ~tif.Active;
`ifdef DISPLAY_DIM_EN
      if ($urandom_range(0, 19) == 0) tif.Brightness = 2'($urandom_range(0, 3));
`endif
      @(negedge clk);
    end
    run(2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
